// File: rtl/param_data_loader.sv
// param_data_loader: sequences feature and weight buffer loads from a fixed-latency memory, then an accumulate sweep.
// Latency: VEC_LEN*(NUM_CH+2)+MEM_LAT+1 cycles from a sampled start_i to done_o; write controls trail their read by MEM_LAT.
// Backpressure: none; memory returns data every cycle and start_i is ignored while a sequence is running.
//
// Ports: clk/rst (async active-low); start_i, feat_base_i, wgt_base_i start a sequence from IDLE;
//        busy_o/done_o report progress; mem_rd_o/addr_o issue reads, mem_data_i returns data MEM_LAT later;
//        mem_data_o, feature_en_o, weight_en_o, elem_sel_o write the buffers; acc_en_o drives the accumulators.
// Optional: define DATA_LOADER_ABORT_EN to add abort_i, which cancels a running sequence with no done_o.
module param_data_loader #(
    parameter int NUM_CH  = 4,
    parameter int VEC_LEN = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          feat_base_i,
    input  logic [ADDR_W-1:0]          wgt_base_i,
`ifdef DATA_LOADER_ABORT_EN
    input  logic                       abort_i,
`endif
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem_rd_o,
    output logic [ADDR_W-1:0]          addr_o,
    input  logic [DATA_W-1:0]          mem_data_i,
    output logic [DATA_W-1:0]          mem_data_o,
    output logic [NUM_CH-1:0]          feature_en_o,
    output logic [NUM_CH-1:0]          weight_en_o,
    output logic [$clog2(VEC_LEN)-1:0] elem_sel_o,
    output logic [NUM_CH-1:0]          acc_en_o
);

    localparam int SEL_W   = $clog2(VEC_LEN);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One counter serves element steps and drain cycles, so it spans the larger of the two.
    localparam int CNT_MAX = (VEC_LEN > MEM_LAT) ? VEC_LEN : MEM_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(MEM_LAT - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, LOAD_F, LOAD_W, DRAIN, ACC, DONE} state_t;

    // Buffer write controls for one read, carried alongside the memory latency.
    typedef struct packed {
        logic              fe;
        logic [NUM_CH-1:0] we;
        logic [SEL_W-1:0]  sel;
    } wr_ctl_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ADDR_W-1:0] feat_base_q, feat_base_d;
    logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acc_en_q, acc_en_d;
    logic [SEL_W-1:0]  acc_sel_q, acc_sel_d;
    wr_ctl_t           pipe_q [MEM_LAT];
    wr_ctl_t           pipe_d [MEM_LAT];
    wr_ctl_t           issue;
    logic              abort_w;

`ifdef DATA_LOADER_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Sequencing: element counter is the inner loop, channel counter the outer loop of the weight load.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        feat_base_d = feat_base_q;
        wgt_base_d  = wgt_base_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    feat_base_d = feat_base_i;
                    wgt_base_d  = wgt_base_i;
                    cnt_d       = '0;
                    ch_d        = '0;
                    state_d     = LOAD_F;
                end
            end
            LOAD_F: begin
                if (cnt_q == V_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_W;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_W: begin
                if (cnt_q == V_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        ch_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == L_LAST) begin
                    cnt_d   = '0;
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACC: begin
                if (cnt_q == V_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // busy_q mirrors the current state being one of the busy states.
        if (abort_w && busy_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            ch_d    = '0;
        end
    end

    // Write controls for the read issued this cycle enter the delay line; an abort empties it.
    always_comb begin
        issue = '0;
        if (state_q == LOAD_F) begin
            issue.fe  = 1'b1;
            issue.sel = cnt_q[SEL_W-1:0];
        end else if (state_q == LOAD_W) begin
            issue.we  = NUM_CH'(1) << ch_q;
            issue.sel = cnt_q[SEL_W-1:0];
        end
        pipe_d[0] = issue;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (abort_w && busy_q) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    // Outputs are registered: decode the next state so they line up with the state they describe.
    always_comb begin
        busy_d    = (state_d == LOAD_F) || (state_d == LOAD_W) ||
                    (state_d == DRAIN)  || (state_d == ACC);
        done_d    = (state_d == DONE);
        mem_rd_d  = (state_d == LOAD_F) || (state_d == LOAD_W);
        acc_en_d  = (state_d == ACC);
        acc_sel_d = (state_d == ACC) ? cnt_d[SEL_W-1:0] : '0;
        addr_d    = '0;
        if (state_d == LOAD_F) begin
            addr_d = feat_base_d + ADDR_W'(cnt_d);
        end else if (state_d == LOAD_W) begin
            // Truncation to ADDR_W gives the intended silent wrap.
            addr_d = wgt_base_d + ADDR_W'(ch_d) * ADDR_W'(VEC_LEN) + ADDR_W'(cnt_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            feat_base_q <= '0;
            wgt_base_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            addr_q      <= '0;
            acc_en_q    <= 1'b0;
            acc_sel_q   <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            feat_base_q <= feat_base_d;
            wgt_base_q  <= wgt_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_q    <= mem_rd_d;
            addr_q      <= addr_d;
            acc_en_q    <= acc_en_d;
            acc_sel_q   <= acc_sel_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign mem_rd_o     = mem_rd_q;
    assign addr_o       = addr_q;
    assign mem_data_o   = mem_data_i;
    assign feature_en_o = {NUM_CH{pipe_q[MEM_LAT-1].fe}};
    assign weight_en_o  = pipe_q[MEM_LAT-1].we;
    assign acc_en_o     = {NUM_CH{acc_en_q}};
    // Delayed load selects and the accumulate select never overlap (DRAIN separates them).
    assign elem_sel_o   = pipe_q[MEM_LAT-1].sel | acc_sel_q;

endmodule
